store_drain_arbiter: RTL

// - Sits between the store queue's retire/writeback output and the single data-cache port.
// - Buffers retired stores (up to 3 per cycle) in an in-order write buffer.
// - Arbitrates the one D-cache port between store drains and load-miss requests,

---
 rtl/store_drain_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/store_drain_arbiter.sv
// In-order store write buffer arbitrating one D-cache port against load misses.
// Define STORE_COALESCE_EN to merge same-word retires into the tail-most entry.
module store_drain_arbiter #(
  parameter int WB_DEPTH   = 4,
  parameter int STARVE_MAX = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [2:0]                ret_valid,
  input  logic [3*ADDR_W-1:0]       ret_addr,
  input  logic [3*DATA_W-1:0]       ret_data,
  input  logic [11:0]               ret_bytes,
  output logic [$clog2(WB_DEPTH):0] wb_space,
  output logic                      wb_empty,
  output logic                      overflow_err,
  input  logic                      load_req,
  input  logic [ADDR_W-1:0]         load_addr,
  output logic                      load_grant,
  output logic                      load_done,
  output logic                      dc_req,
  output logic                      dc_we,
  output logic [ADDR_W-1:0]         dc_addr,
  output logic [DATA_W-1:0]         dc_wdata,
  output logic [3:0]                dc_be,
  input  logic                      dc_ack
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    STORE_BUSY,
    LOAD_BUSY
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] addr_q [WB_DEPTH];
  logic [ADDR_W-1:0] addr_n [WB_DEPTH];
  logic [DATA_W-1:0] data_q [WB_DEPTH];
  logic [DATA_W-1:0] data_n [WB_DEPTH];
  logic [3:0]        be_q   [WB_DEPTH];
  logic [3:0]        be_n   [WB_DEPTH];
  logic [WB_DEPTH-1:0] vld_q, vld_n;

  logic [PW-1:0] head, tail, tail_n;
  logic [CW-1:0] space, space_n, used, pcnt;
  logic [SW-1:0] starve;

  logic full, conflict, pop, ovf;
  logic grant, store_go;

`ifdef STORE_COALESCE_EN
  logic [PW-1:0] last;
  logic          last_ok;
`endif

  assign wb_space = space;
  assign wb_empty = (space == CW'(WB_DEPTH));
  assign full     = (space == '0);
  assign pop      = (state == STORE_BUSY) && dc_ack;

  assign pcnt = CW'(ret_valid[0]) + CW'(ret_valid[1]) + CW'(ret_valid[2]);
  assign ovf  = (pcnt > space);

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (vld_q[i] &&
          addr_q[i][ADDR_W-1:2] == load_addr[ADDR_W-1:2])
        conflict = 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    grant    = 1'b0;
    store_go = 1'b0;
    unique case (state)
      IDLE: begin
        if (!wb_empty &&
            (full || starve == SW'(STARVE_MAX) ||
             conflict || !load_req)) begin
          store_go = 1'b1;
          state_n  = STORE_BUSY;
        end else if (load_req) begin
          grant   = 1'b1;
          state_n = LOAD_BUSY;
        end
      end
      STORE_BUSY: if (dc_ack) state_n = IDLE;
      LOAD_BUSY:  if (dc_ack) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  assign load_grant = grant && !reset;
  assign load_done  = (state == LOAD_BUSY) && dc_ack && !reset;

  always_comb begin
    addr_n  = addr_q;
    data_n  = data_q;
    be_n    = be_q;
    vld_n   = vld_q;
    tail_n  = tail;
    used    = '0;
`ifdef STORE_COALESCE_EN
    last    = tail - PW'(1);
    last_ok = !wb_empty;
`endif
    if (pop) vld_n[head] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (ret_valid[k]) begin
`ifdef STORE_COALESCE_EN
        // The head is frozen once it is issuing or about to issue.
        if (last_ok &&
            addr_n[last][ADDR_W-1:2] ==
              ret_addr[k*ADDR_W+2 +: ADDR_W-2] &&
            !(last == head &&
              (state == STORE_BUSY || store_go))) begin
          for (int b = 0; b < 4; b++) begin
            if (ret_bytes[4*k+b])
              data_n[last][8*b +: 8] = ret_data[k*DATA_W+8*b +: 8];
          end
          be_n[last] = be_n[last] | ret_bytes[4*k +: 4];
        end else
`endif
        if (used < space) begin
          addr_n[tail_n] = ret_addr[k*ADDR_W +: ADDR_W];
          data_n[tail_n] = ret_data[k*DATA_W +: DATA_W];
          be_n[tail_n]   = ret_bytes[4*k +: 4];
          vld_n[tail_n]  = 1'b1;
`ifdef STORE_COALESCE_EN
          last           = tail_n;
          last_ok        = 1'b1;
`endif
          tail_n         = tail_n + PW'(1);
          used           = used + CW'(1);
        end
      end
    end
  end

  assign space_n = space + CW'(pop) - used;

  always_ff @(posedge clock) begin
    addr_q <= addr_n;
    data_q <= data_n;
    be_q   <= be_n;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      head         <= '0;
      tail         <= '0;
      space        <= CW'(WB_DEPTH);
      vld_q        <= '0;
      overflow_err <= 1'b0;
      starve       <= '0;
      dc_req       <= 1'b0;
      dc_we        <= 1'b0;
      dc_addr      <= '0;
      dc_wdata     <= '0;
      dc_be        <= '0;
    end else begin
      state <= state_n;
      tail  <= tail_n;
      space <= space_n;
      vld_q <= vld_n;
      if (pop) head <= head + PW'(1);
      if (ovf) overflow_err <= 1'b1;
      if (pop)
        starve <= '0;
      else if (grant && !wb_empty)
        starve <= starve + SW'(1);
      if (store_go) begin
        dc_req   <= 1'b1;
        dc_we    <= 1'b1;
        dc_addr  <= addr_q[head];
        dc_wdata <= data_q[head];
        dc_be    <= be_q[head];
      end else if (grant) begin
        dc_req   <= 1'b1;
        dc_we    <= 1'b0;
        dc_addr  <= load_addr;
        dc_wdata <= '0;
        dc_be    <= '0;
      end else if (dc_ack && state != IDLE) begin
        dc_req <= 1'b0;
        dc_we  <= 1'b0;
      end
    end
  end

endmodule
